pac_man_tile_drawer: RTL and testbench

Frame-buffer writer for the player sprite. It accepts a new maze tile index from the movement logic (32x32 grid, row-major, index = row*32 + col). It erases the previously drawn tile to background, then paints the new tile, one pixel per accepted write, over a valid/ready write port into the VGA frame buffer. It sits between the movement logic's next_block output and the frame buffer's write side.

---
 rtl/pac_man_tile_drawer.sv | 219 +++++++++++++++++++++
 tb/tb_pac_man_tile_drawer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_man_tile_drawer.sv
// pac_man_tile_drawer: erases the player's previous maze tile and paints the
// new one into the VGA frame buffer, one pixel per accepted valid/ready write.
// Optional build macro TILE_DRAWER_ROUND_EN: when defined, DRAW paints a disc
// inscribed in the tile (background elsewhere) instead of a solid square.
module pac_man_tile_drawer #(
   parameter int                  TILE_PX   = 8,
   parameter int                  GRID_W    = 32,
   parameter int                  X_W       = 10,
   parameter int                  Y_W       = 9,
   parameter int                  COLOR_W   = 3,
   parameter logic [COLOR_W-1:0]  PAC_COLOR = 3'b110,
   parameter logic [COLOR_W-1:0]  BG_COLOR  = 3'b000,
   parameter int                  X_OFFSET  = 0,
   parameter int                  Y_OFFSET  = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [9:0]         block_in,
   input  logic               wr_ready,
   output logic               wr_en,
   output logic [X_W-1:0]     wr_x,
   output logic [Y_W-1:0]     wr_y,
   output logic [COLOR_W-1:0] wr_color,
   output logic               busy,
   output logic               done
);

   localparam int PX_W  = $clog2(TILE_PX);
   localparam int COL_W = $clog2(GRID_W);
   localparam logic [PX_W-1:0] PX_MAX = PX_W'(TILE_PX - 1);
   localparam logic [9:0] RESET_BLOCK = 10'd495;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ERASE  = 2'd1,
      DRAW   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PX_W-1:0]      px_q, px_d;
   logic [PX_W-1:0]      py_q, py_d;
   logic [9:0]           new_block_q, new_block_d;
   logic [9:0]           old_block_q, old_block_d;
   logic                 pending_q, pending_d;
   logic [9:0]           pending_block_q, pending_block_d;
   logic                 wr_en_q, wr_en_d;
   logic [X_W-1:0]       wr_x_q, wr_x_d;
   logic [Y_W-1:0]       wr_y_q, wr_y_d;
   logic [COLOR_W-1:0]   wr_color_q, wr_color_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 wr_accept;
   logic                 launch;
   logic [9:0]           launch_block;
   logic [COLOR_W-1:0]   draw_col;

   // Pixel x: column of the tile scaled by the tile size plus the in-tile offset.
   function automatic logic [X_W-1:0] pix_x(input logic [9:0] blk, input logic [PX_W-1:0] p);
      logic [31:0] t;
      t = 32'(X_OFFSET) + (32'(blk[COL_W-1:0]) << PX_W) + 32'(p);
      return t[X_W-1:0];
   endfunction

   // Pixel y: row of the tile scaled by the tile size plus the in-tile offset.
   function automatic logic [Y_W-1:0] pix_y(input logic [9:0] blk, input logic [PX_W-1:0] p);
      logic [31:0] t;
      t = 32'(Y_OFFSET) + (32'(blk[9:COL_W]) << PX_W) + 32'(p);
      return t[Y_W-1:0];
   endfunction

`ifdef TILE_DRAWER_ROUND_EN
   // Disc test in doubled coordinates so the tile centre lands on an integer.
   function automatic logic in_disc(input logic [PX_W-1:0] x, input logic [PX_W-1:0] y);
      int dx;
      int dy;
      dx = 2 * int'(x) - (TILE_PX - 1);
      dy = 2 * int'(y) - (TILE_PX - 1);
      return (dx * dx + dy * dy) <= (TILE_PX * TILE_PX);
   endfunction
`endif

   // Next-state, counter and registered-output computation for the sequencer.
   always_comb begin
      state_d         = state_q;
      px_d            = px_q;
      py_d            = py_q;
      new_block_d     = new_block_q;
      old_block_d     = old_block_q;
      pending_d       = pending_q;
      pending_block_d = pending_block_q;
      done_d          = 1'b0;
      launch          = 1'b0;
      launch_block    = block_in;
      wr_accept       = wr_en_q && wr_ready;
      wr_en_d         = 1'b0;
      wr_x_d          = wr_x_q;
      wr_y_d          = wr_y_q;
      wr_color_d      = wr_color_q;
      draw_col        = PAC_COLOR;

      case (state_q)
         IDLE: begin
            if (start) begin
               launch       = 1'b1;
               launch_block = block_in;
            end
         end
         ERASE, DRAW: begin
            if (start) begin
               pending_d       = 1'b1;
               pending_block_d = block_in;
            end
            if (wr_accept) begin
               if (px_q == PX_MAX) begin
                  px_d = '0;
                  if (py_q == PX_MAX) begin
                     py_d = '0;
                     if (state_q == ERASE) begin
                        state_d = DRAW;
                     end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                     end
                  end else begin
                     py_d = py_q + 1'b1;
                  end
               end else begin
                  px_d = px_q + 1'b1;
               end
            end
         end
         FINISH: begin
            old_block_d = new_block_q;
            pending_d   = 1'b0;
            if (start) begin
               launch       = 1'b1;
               launch_block = block_in;
            end else if (pending_q) begin
               launch       = 1'b1;
               launch_block = pending_block_q;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         new_block_d = launch_block;
         px_d        = '0;
         py_d        = '0;
         state_d     = (launch_block != old_block_d) ? ERASE : DRAW;
      end

`ifdef TILE_DRAWER_ROUND_EN
      draw_col = in_disc(px_d, py_d) ? PAC_COLOR : BG_COLOR;
`else
      draw_col = PAC_COLOR;
`endif

      if (state_d == ERASE) begin
         wr_en_d    = 1'b1;
         wr_x_d     = pix_x(old_block_d, px_d);
         wr_y_d     = pix_y(old_block_d, py_d);
         wr_color_d = BG_COLOR;
      end else if (state_d == DRAW) begin
         wr_en_d    = 1'b1;
         wr_x_d     = pix_x(new_block_d, px_d);
         wr_y_d     = pix_y(new_block_d, py_d);
         wr_color_d = draw_col;
      end

      busy_d = (state_d != IDLE) || pending_d;
   end

   // State, counters and registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         px_q            <= '0;
         py_q            <= '0;
         new_block_q     <= '0;
         old_block_q     <= RESET_BLOCK;
         pending_q       <= 1'b0;
         pending_block_q <= '0;
         wr_en_q         <= 1'b0;
         wr_x_q          <= '0;
         wr_y_q          <= '0;
         wr_color_q      <= BG_COLOR;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         px_q            <= px_d;
         py_q            <= py_d;
         new_block_q     <= new_block_d;
         old_block_q     <= old_block_d;
         pending_q       <= pending_d;
         pending_block_q <= pending_block_d;
         wr_en_q         <= wr_en_d;
         wr_x_q          <= wr_x_d;
         wr_y_q          <= wr_y_d;
         wr_color_q      <= wr_color_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_x     = wr_x_q;
   assign wr_y     = wr_y_q;
   assign wr_color = wr_color_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_pac_man_tile_drawer.sv
// Scoreboard bench for pac_man_tile_drawer: expected writes and done cycles are
// queued when a start is issued; a monitor pops and compares on each event.
module tb_pac_man_tile_drawer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] block_in;
   logic       wr_ready;
   logic       wr_en;
   logic [9:0] wr_x;
   logic [8:0] wr_y;
   logic [2:0] wr_color;
   logic       busy;
   logic       done;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t expQ[$];
   int   expDoneQ[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   readyMode = 0;
   int   readyRef = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle index: number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   pac_man_tile_drawer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .block_in (block_in),
      .wr_ready (wr_ready),
      .wr_en    (wr_en),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_color (wr_color),
      .busy     (busy),
      .done     (done)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [2:0] modelColor(input int px, input int py);
`ifdef TILE_DRAWER_ROUND_EN
      int dx;
      int dy;
      dx = 2 * px - 7;
      dy = 2 * py - 7;
      return ((dx * dx + dy * dy) <= 64) ? 3'b110 : 3'b000;
`else
      return (px >= 0 && py >= 0) ? 3'b110 : 3'b000;
`endif
   endfunction

   // Queue the first 'count' raster-order writes of one tile (erase or draw).
   task automatic pushTile(input int blk, input bit isDraw, input int count);
      pix_t e;
      for (int k = 0; k < count; k++) begin
         e.x = 10'(((blk % 32) * 8) + (k % 8));
         e.y = 9'(((blk / 32) * 8) + (k / 8));
         e.c = isDraw ? modelColor(k % 8, k / 8) : 3'b000;
         expQ.push_back(e);
      end
   endtask

   // Pulse start for one cycle; returns the cycle in which start was high.
   task automatic applyStimulus(input int blk, output int sc);
      start    = 1'b1;
      block_in = 10'(blk);
      sc       = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic runUntilIdle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      checkOutput("idle_timeout", busy, 0);
   endtask

   // Frame-buffer ready driver: always ready, or alternating from readyRef.
   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         wr_ready = (readyMode == 0) ? 1'b1 : (((cyc - readyRef) % 2) == 0);
      end
   end

   // Monitor: compares accepted writes, held requests and done pulses.
   initial begin
      pix_t e;
      pix_t heldV;
      bit   held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            if (held) begin
               checkOutput("hold_en", int'(wr_en), 1);
               checkOutput("hold_pix", int'({wr_x, wr_y, wr_color}), int'(heldV));
            end
            held = 1'b0;
            if (wr_en && wr_ready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_write actual=(%0d,%0d,%0d) expected=none", wr_x, wr_y, wr_color);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("write_x", int'(wr_x), int'(e.x));
                  checkOutput("write_y", int'(wr_y), int'(e.y));
                  checkOutput("write_color", int'(wr_color), int'(e.c));
               end
            end else if (wr_en) begin
               held  = 1'b1;
               heldV = {wr_x, wr_y, wr_color};
            end
            if (done) begin
               if (expDoneQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_done actual=cycle %0d expected=none", cyc);
               end else begin
                  checkOutput("done_cycle", cyc, expDoneQ.pop_front());
               end
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int sc;
      int tmp;
      reset    = 1'b1;
      start    = 1'b0;
      block_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_wr_en", int'(wr_en), 0);
      checkOutput("reset_wr_x", int'(wr_x), 0);
      checkOutput("reset_wr_y", int'(wr_y), 0);
      checkOutput("reset_wr_color", int'(wr_color), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] draw after reset");
      pushTile(495, 1'b1, 64);
      applyStimulus(495, sc);
      expDoneQ.push_back(sc + 65);
      checkOutput("busy_after_start", int'(busy), 1);
      runUntilIdle(400);

      $display("[TB] move right");
      pushTile(495, 1'b0, 64);
      pushTile(496, 1'b1, 64);
      applyStimulus(496, sc);
      expDoneQ.push_back(sc + 129);
      runUntilIdle(400);

      pushTile(496, 1'b0, 64);
      pushTile(495, 1'b1, 64);
      applyStimulus(495, sc);
      expDoneQ.push_back(sc + 129);
      runUntilIdle(400);

      $display("[TB] backpressure");
      readyMode = 1;
      readyRef  = cyc;
      pushTile(495, 1'b0, 64);
      pushTile(496, 1'b1, 64);
      applyStimulus(496, sc);
      expDoneQ.push_back(sc + 257);
      runUntilIdle(800);
      readyMode = 0;

      pushTile(496, 1'b0, 64);
      pushTile(495, 1'b1, 64);
      applyStimulus(495, sc);
      expDoneQ.push_back(sc + 129);
      runUntilIdle(400);

      $display("[TB] pending coalescing");
      pushTile(495, 1'b0, 64);
      pushTile(496, 1'b1, 64);
      applyStimulus(496, sc);
      expDoneQ.push_back(sc + 129);
      repeat (10) @(posedge clk);
      #1;
      applyStimulus(464, tmp);
      repeat (5) @(posedge clk);
      #1;
      pushTile(496, 1'b0, 64);
      pushTile(528, 1'b1, 64);
      applyStimulus(528, tmp);
      expDoneQ.push_back(sc + 258);
      checkOutput("busy_pending", int'(busy), 1);
      runUntilIdle(800);

      $display("[TB] reset mid draw");
      pushTile(528, 1'b0, 64);
      pushTile(495, 1'b1, 30);
      applyStimulus(495, sc);
      repeat (94) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_wr_en", int'(wr_en), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pushTile(495, 1'b1, 64);
      applyStimulus(495, sc);
      expDoneQ.push_back(sc + 65);
      runUntilIdle(400);

      $display("[TB] grid corner");
      pushTile(495, 1'b0, 64);
      pushTile(0, 1'b1, 64);
      applyStimulus(0, sc);
      expDoneQ.push_back(sc + 129);
      runUntilIdle(400);
      pushTile(0, 1'b0, 64);
      pushTile(1023, 1'b1, 64);
      applyStimulus(1023, sc);
      expDoneQ.push_back(sc + 129);
      runUntilIdle(400);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("writes_left", expQ.size(), 0);
      checkOutput("done_left", expDoneQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
